instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the decode stage: turns symbolic RV32I operation requests (op, rd, rs1, rs2, imm) into 32-bit instruction words.
- Each word is buffered in a small FIFO, tagged with a sequential word address and drained over a valid/ready stream.
- Sits between the host/test loader and the instruction-memory write port; used for program preload and self-test streams.

Parameters:
- DEPTH, 4, output FIFO entries (power of 2, >=2)
- ADDR_W, 10, width of the word-address tag
- BASE_ADDR, 0, address tag given to the first word after reset or flush

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of FIFO, address counter and error flag
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_op  in  5  enc_op_t operation code
- req_rd  in  5  destination register
- req_rs1  in  5  source register 1
- req_rs2  in  5  source register 2
- req_imm  in  32  immediate: signed byte offset or value; for U-type, bits [31:12] are used
- out_valid  out  1  word available
- out_ready  in  1  consumer takes word when valid&ready
- out_instr  out  32  encoded instruction
- out_addr  out  ADDR_W  word address tag
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- err  out  1  sticky: illegal op or immediate out of range

Behaviour:
- Reset: all outputs are 0 (req_ready=0 while rst_n low), FIFO empty, address counter=BASE_ADDR. req_ready rises in the first cycle after reset release.
- enc_op_t codes 0..30: ADD SUB AND OR XOR SLL SRL SRA SLT SLTU, ADDI ANDI ORI XORI SLLI SRLI SRAI SLTI SLTIU, LW SW, BEQ BNE BLT BGE BLTU BGEU, JAL JALR, LUI AUIPC. Code 31 is illegal.
- Encoding uses the codebase opcode/funct3/funct7 constants:
  - R-type: SUB and SRA use funct7=0100000; all others use 0000000.
  - Shift-immediates: shamt=imm[4:0]; funct7=0100000 for SRAI, 0000000 otherwise.
  - I-type covers OP-IMM, LW (funct3=010) and JALR.
  - SW uses funct3=010.
  - B-type and J-type use standard bit scrambling.
  - Fields unused by a format come from the format definition, never from stray request inputs.
- Range checks (violation means the request is accepted and dropped):
  - I-type: imm in [-2048,2047].
  - Shifts: imm in [0,31].
  - B-type: imm in [-4096,4094] and even.
  - JAL: imm in [-1048576,1048574] and even.
  - U-type: no check; imm[11:0] ignored.
- On a dropped request: err is set, no push, address not advanced.
- Handshake: req_ready = !flush && count<DEPTH. There is no same-cycle pass-through when full.
- Latency: a request accepted in cycle t gives out_valid=1 in cycle t+1 if the FIFO was empty.
- out_instr/out_addr stay stable while out_valid && !out_ready.
- Push assigns the current address counter value, then increments it. The counter wraps modulo 2^ADDR_W with no error.
- Simultaneous push and pop keeps count unchanged; legal whenever count<DEPTH. Pop from empty is impossible (out_valid=0).
- flush: next cycle count=0, out_valid=0, address=BASE_ADDR, err=0. Any request presented during the flush cycle is not accepted.
- rst_n asserted mid-stream discards all contents immediately; there is no partial output.
- err is sticky until flush or reset.

Decomposition:
- Shared package holds:
  - enc_op_t enum
  - existing OPCODE_/FUNCT3_/FUNCT7_ constants (reused, not redefined)
  - immediate range limit constants
- Pure combinational sub-module instr_pack (op, fields → instr, illegal), reusable by testbenches as a reference encoder.
- The FIFO/counter logic stays in instr_encoder.

Test Plan:
- ADD x1,x2,x3; SUB x5,x6,x7; ADDI x1,x0,5 back-to-back, out_ready=1 → 0x003100B3 @0, 0x407302B3 @1, 0x00500093 @2, each one cycle after acceptance.
- SW x2,4(x1); BEQ x1,x2,+8; LUI x1,0x12345000; SRAI x1,x2,3 → 0x0020A223, 0x00208463, 0x123450B7, 0x40315093.
- out_ready=0, push 5 requests → req_ready low after 4 (count=4). Then out_ready=1 with req_valid held → simultaneous push/pop, 5th word gets addr 4, order preserved.
- ADDI imm=2048, then BEQ imm=3, then op=31 → none emitted, err=1, address counter unchanged. A following valid ADDI gets the next address.
- ADDR_W=2: push 5 words → tags 0,1,2,3,0.
- Flush with 3 entries queued and err=1 → next cycle count=0, out_valid=0, err=0; next word tagged BASE_ADDR. Async rst_n pulse mid-stream → same cleared state.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoding definitions: request op codes, opcode/funct fields and immediate limits.
package instr_encoder_pkg;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
        OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI, OP_SRLI, OP_SRAI, OP_SLTI, OP_SLTIU,
        OP_LW, OP_SW,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_JAL, OP_JALR,
        OP_LUI, OP_AUIPC
    } enc_op_t;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_J, FMT_U, FMT_BAD
    } enc_fmt_t;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

    localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
    localparam logic [2:0] FUNCT3_SLL     = 3'b001;
    localparam logic [2:0] FUNCT3_SLT     = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
    localparam logic [2:0] FUNCT3_XOR     = 3'b100;
    localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
    localparam logic [2:0] FUNCT3_OR      = 3'b110;
    localparam logic [2:0] FUNCT3_AND     = 3'b111;
    localparam logic [2:0] FUNCT3_LW      = 3'b010;
    localparam logic [2:0] FUNCT3_SW      = 3'b010;
    localparam logic [2:0] FUNCT3_JALR    = 3'b000;
    localparam logic [2:0] FUNCT3_BEQ     = 3'b000;
    localparam logic [2:0] FUNCT3_BNE     = 3'b001;
    localparam logic [2:0] FUNCT3_BLT     = 3'b100;
    localparam logic [2:0] FUNCT3_BGE     = 3'b101;
    localparam logic [2:0] FUNCT3_BLTU    = 3'b110;
    localparam logic [2:0] FUNCT3_BGEU    = 3'b111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    localparam int IMM_I_MIN  = -2048;
    localparam int IMM_I_MAX  = 2047;
    localparam int IMM_SH_MIN = 0;
    localparam int IMM_SH_MAX = 31;
    localparam int IMM_B_MIN  = -4096;
    localparam int IMM_B_MAX  = 4094;
    localparam int IMM_J_MIN  = -1048576;
    localparam int IMM_J_MAX  = 1048574;

    function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
        return ($signed(v) >= lo) && ($signed(v) <= hi);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I encoder: op + register fields + immediate -> 32-bit word, with
// an illegal flag for unknown ops or out-of-range immediates.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  enc_op_t     op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        illegal
);

    enc_fmt_t   fmt;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;

    always_comb begin
        fmt = FMT_BAD;
        opc = '0;
        f3  = '0;
        f7  = FUNCT7_BASE;
        case (op)
            OP_ADD:   begin fmt = FMT_R;  opc = OPCODE_OP;     f3 = FUNCT3_ADD_SUB; end
            OP_SUB:   begin fmt = FMT_R;  opc = OPCODE_OP;     f3 = FUNCT3_ADD_SUB; f7 = FUNCT7_ALT; end
            OP_AND:   begin fmt = FMT_R;  opc = OPCODE_OP;     f3 = FUNCT3_AND;     end
            OP_OR:    begin fmt = FMT_R;  opc = OPCODE_OP;     f3 = FUNCT3_OR;      end
            OP_XOR:   begin fmt = FMT_R;  opc = OPCODE_OP;     f3 = FUNCT3_XOR;     end
            OP_SLL:   begin fmt = FMT_R;  opc = OPCODE_OP;     f3 = FUNCT3_SLL;     end
            OP_SRL:   begin fmt = FMT_R;  opc = OPCODE_OP;     f3 = FUNCT3_SRL_SRA; end
            OP_SRA:   begin fmt = FMT_R;  opc = OPCODE_OP;     f3 = FUNCT3_SRL_SRA; f7 = FUNCT7_ALT; end
            OP_SLT:   begin fmt = FMT_R;  opc = OPCODE_OP;     f3 = FUNCT3_SLT;     end
            OP_SLTU:  begin fmt = FMT_R;  opc = OPCODE_OP;     f3 = FUNCT3_SLTU;    end
            OP_ADDI:  begin fmt = FMT_I;  opc = OPCODE_OP_IMM; f3 = FUNCT3_ADD_SUB; end
            OP_ANDI:  begin fmt = FMT_I;  opc = OPCODE_OP_IMM; f3 = FUNCT3_AND;     end
            OP_ORI:   begin fmt = FMT_I;  opc = OPCODE_OP_IMM; f3 = FUNCT3_OR;      end
            OP_XORI:  begin fmt = FMT_I;  opc = OPCODE_OP_IMM; f3 = FUNCT3_XOR;     end
            OP_SLTI:  begin fmt = FMT_I;  opc = OPCODE_OP_IMM; f3 = FUNCT3_SLT;     end
            OP_SLTIU: begin fmt = FMT_I;  opc = OPCODE_OP_IMM; f3 = FUNCT3_SLTU;    end
            OP_SLLI:  begin fmt = FMT_SH; opc = OPCODE_OP_IMM; f3 = FUNCT3_SLL;     end
            OP_SRLI:  begin fmt = FMT_SH; opc = OPCODE_OP_IMM; f3 = FUNCT3_SRL_SRA; end
            OP_SRAI:  begin fmt = FMT_SH; opc = OPCODE_OP_IMM; f3 = FUNCT3_SRL_SRA; f7 = FUNCT7_ALT; end
            OP_LW:    begin fmt = FMT_I;  opc = OPCODE_LOAD;   f3 = FUNCT3_LW;      end
            OP_SW:    begin fmt = FMT_S;  opc = OPCODE_STORE;  f3 = FUNCT3_SW;      end
            OP_BEQ:   begin fmt = FMT_B;  opc = OPCODE_BRANCH; f3 = FUNCT3_BEQ;     end
            OP_BNE:   begin fmt = FMT_B;  opc = OPCODE_BRANCH; f3 = FUNCT3_BNE;     end
            OP_BLT:   begin fmt = FMT_B;  opc = OPCODE_BRANCH; f3 = FUNCT3_BLT;     end
            OP_BGE:   begin fmt = FMT_B;  opc = OPCODE_BRANCH; f3 = FUNCT3_BGE;     end
            OP_BLTU:  begin fmt = FMT_B;  opc = OPCODE_BRANCH; f3 = FUNCT3_BLTU;    end
            OP_BGEU:  begin fmt = FMT_B;  opc = OPCODE_BRANCH; f3 = FUNCT3_BGEU;    end
            OP_JAL:   begin fmt = FMT_J;  opc = OPCODE_JAL;    end
            OP_JALR:  begin fmt = FMT_I;  opc = OPCODE_JALR;   f3 = FUNCT3_JALR;    end
            OP_LUI:   begin fmt = FMT_U;  opc = OPCODE_LUI;    end
            OP_AUIPC: begin fmt = FMT_U;  opc = OPCODE_AUIPC;  end
            default:  fmt = FMT_BAD;
        endcase
    end

    // Each format only pulls the fields it defines; stray rd/rs inputs never leak in.
    always_comb begin
        instr   = '0;
        illegal = 1'b0;
        case (fmt)
            FMT_R:  instr = {f7, rs2, rs1, f3, rd, opc};
            FMT_I: begin
                instr   = {imm[11:0], rs1, f3, rd, opc};
                illegal = !in_range(imm, IMM_I_MIN, IMM_I_MAX);
            end
            FMT_SH: begin
                instr   = {f7, imm[4:0], rs1, f3, rd, opc};
                illegal = !in_range(imm, IMM_SH_MIN, IMM_SH_MAX);
            end
            FMT_S: begin
                instr   = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
                illegal = !in_range(imm, IMM_I_MIN, IMM_I_MAX);
            end
            FMT_B: begin
                instr   = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
                illegal = !in_range(imm, IMM_B_MIN, IMM_B_MAX) || imm[0];
            end
            FMT_J: begin
                instr   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
                illegal = !in_range(imm, IMM_J_MIN, IMM_J_MAX) || imm[0];
            end
            FMT_U:  instr = {imm[31:12], rd, opc};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes requests into RV32I words, queues them with an address tag; 1-cycle latency
// when empty. req_ready drops when the FIFO is full or during flush (no full pass-through).
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  enc_op_t                req_op,
    input  logic [4:0]             req_rd,
    input  logic [4:0]             req_rs1,
    input  logic [4:0]             req_rs2,
    input  logic [31:0]            req_imm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instr,
    output logic [ADDR_W-1:0]      out_addr,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]       mem_instr [DEPTH];
    logic [ADDR_W-1:0] mem_addr  [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic [ADDR_W-1:0] next_addr;
    logic              running;
    logic              err_q;
    logic [31:0]       pk_instr;
    logic              pk_illegal;
    logic              accept;
    logic              push;
    logic              pop;

    instr_pack u_pack (
        .op      (req_op),
        .rd      (req_rd),
        .rs1     (req_rs1),
        .rs2     (req_rs2),
        .imm     (req_imm),
        .instr   (pk_instr),
        .illegal (pk_illegal)
    );

    // running holds ready low through reset and releases it one edge later.
    assign req_ready = running && !flush && (cnt < FULL);
    assign accept    = req_valid && req_ready;
    assign push      = accept && !pk_illegal;
    assign out_valid = (cnt != '0);
    assign pop       = out_valid && out_ready;
    assign out_instr = out_valid ? mem_instr[rd_ptr] : '0;
    assign out_addr  = out_valid ? mem_addr[rd_ptr]  : '0;
    assign count     = cnt;
    assign err       = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running   <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            next_addr <= BASE_ADDR;
            err_q     <= 1'b0;
        end else begin
            running <= 1'b1;
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                cnt       <= '0;
                next_addr <= BASE_ADDR;
                err_q     <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr    <= wr_ptr + 1'b1;
                    next_addr <= next_addr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    cnt <= cnt + 1'b1;
                end else if (pop && !push) begin
                    cnt <= cnt - 1'b1;
                end
                if (accept && pk_illegal) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    // Storage needs no reset: outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= pk_instr;
            mem_addr[wr_ptr]  <= next_addr;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a driver queues expected words, a monitor checks them.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, req_valid, req_ready, out_valid, out_ready, err;
    enc_op_t     req_op;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [31:0] req_imm, out_instr;
    logic [9:0]  out_addr;
    logic [2:0]  count;

    logic        s_req_valid, s_req_ready, s_out_valid, s_out_ready, s_err;
    logic [31:0] s_out_instr;
    logic [1:0]  s_out_addr;
    logic [2:0]  s_count;

    instr_encoder dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .count(count), .err(err)
    );

    instr_encoder #(.ADDR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_op(OP_ADDI),
        .req_rd(5'd1), .req_rs1(5'd0), .req_rs2(5'd0), .req_imm(32'd7),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_instr(s_out_instr),
        .out_addr(s_out_addr), .count(s_count), .err(s_err)
    );

    typedef struct {
        logic [31:0] instr;
        logic [9:0]  addr;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [9:0]  model_addr;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          s_seen = 0;
    logic        hold_vld = 1'b0;
    logic [31:0] hold_instr;
    logic [9:0]  hold_addr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (hold_vld) begin
                check("hold_instr", out_instr, hold_instr);
                check("hold_addr", {22'b0, out_addr}, {22'b0, hold_addr});
            end
            if (out_ready) begin
                hold_vld = 1'b0;
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got 0x%08h, expected no word", out_instr);
                end else begin
                    mon_e = q.pop_front();
                    check("instr", out_instr, mon_e.instr);
                    check("addr", {22'b0, out_addr}, {22'b0, mon_e.addr});
                    if (mon_e.lat) check("latency", cyc, mon_e.acc + 1);
                end
            end else begin
                hold_vld   = 1'b1;
                hold_instr = out_instr;
                hold_addr  = out_addr;
            end
        end else begin
            hold_vld = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && s_out_valid && s_out_ready) begin
            check("wrap_instr", s_out_instr, 32'h00700093);
            check("wrap_addr", {30'b0, s_out_addr}, 32'(s_seen % 4));
            s_seen++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input enc_op_t op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm,
                        input logic [31:0] exp_instr, input bit legal, input bit lat);
        int n = 0;
        bit acc = 1'b0;
        req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
        req_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            if (req_ready) begin
                acc = 1'b1;
                if (legal) begin
                    q.push_back('{exp_instr, model_addr, cyc, lat});
                    model_addr++;
                end
            end
            @(posedge clk);
            #1;
            n++;
        end
        req_valid = 1'b0;
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: req_ready stayed 0, expected 1 within 50 cycles");
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 100) begin
            step(1);
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d words pending, expected 0", q.size());
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; out_ready = 1'b0;
        req_op = OP_ADD; req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
        s_req_valid = 1'b0; s_out_ready = 1'b0;
        model_addr = '0;
        #12;
        check("rst_req_ready", req_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_count", {29'b0, count}, 0);
        check("rst_err", err, 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_out_addr", {22'b0, out_addr}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1);
        check("ready_after_reset", req_ready, 1);

        // back-to-back R/I words, one cycle after acceptance each
        out_ready = 1'b1;
        send(OP_ADD,  5'd1, 5'd2, 5'd3, 32'd0, 32'h003100B3, 1, 1);
        send(OP_SUB,  5'd5, 5'd6, 5'd7, 32'd0, 32'h407302B3, 1, 1);
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1, 1);
        drain();

        // other formats, stray fields set to 31 where the format ignores them
        send(OP_SW,    5'd31, 5'd1,  5'd2,  32'd4,          32'h0020A223, 1, 0);
        send(OP_BEQ,   5'd31, 5'd1,  5'd2,  32'd8,          32'h00208463, 1, 0);
        send(OP_LUI,   5'd1,  5'd31, 5'd31, 32'h12345FFF,   32'h123450B7, 1, 0);
        send(OP_SRAI,  5'd1,  5'd2,  5'd31, 32'd3,          32'h40315093, 1, 0);
        send(OP_SLTU,  5'd4,  5'd5,  5'd6,  32'd0,          32'h0062B233, 1, 0);
        send(OP_LW,    5'd3,  5'd2,  5'd31, 32'hFFFFFFFC,   32'hFFC12183, 1, 0);
        send(OP_JALR,  5'd1,  5'd5,  5'd31, 32'd0,          32'h000280E7, 1, 0);
        send(OP_AUIPC, 5'd5,  5'd31, 5'd31, 32'h00001FFF,   32'h00001297, 1, 0);
        send(OP_JAL,   5'd0,  5'd31, 5'd31, 32'd8,          32'h0080006F, 1, 0);
        send(OP_ADDI,  5'd2,  5'd1,  5'd31, 32'hFFFFF800,   32'h80008113, 1, 0);
        send(OP_BEQ,   5'd0,  5'd0,  5'd0,  32'hFFFFF000,   32'h80000063, 1, 0);
        send(OP_SLLI,  5'd1,  5'd2,  5'd31, 32'd31,         32'h01F11093, 1, 0);
        drain();

        // illegal requests are accepted and dropped
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048,     32'h0, 0, 0);
        send(OP_BEQ,  5'd0, 5'd1, 5'd2, 32'd3,        32'h0, 0, 0);
        send(enc_op_t'(5'd31), 5'd1, 5'd1, 5'd1, 32'd0, 32'h0, 0, 0);
        send(OP_SRAI, 5'd1, 5'd2, 5'd0, 32'd32,       32'h0, 0, 0);
        send(OP_JAL,  5'd1, 5'd0, 5'd0, 32'd1048576,  32'h0, 0, 0);
        send(OP_BEQ,  5'd0, 5'd1, 5'd2, 32'd4096,     32'h0, 0, 0);
        check("err_set", err, 1);
        check("err_no_push", {29'b0, count}, 0);
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1, 1);
        drain();

        // flush with three words queued and err set
        out_ready = 1'b0;
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd1, 32'h00100093, 1, 0);
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2, 32'h00200093, 1, 0);
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd3, 32'h00300093, 1, 0);
        send(enc_op_t'(5'd31), 5'd0, 5'd0, 5'd0, 32'd0, 32'h0, 0, 0);
        check("pre_flush_count", {29'b0, count}, 3);
        check("pre_flush_err", err, 1);
        flush = 1'b1;
        req_op = OP_ADD; req_valid = 1'b1;
        @(negedge clk);
        check("flush_ready", req_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        q.delete();
        model_addr = '0;
        check("flush_count", {29'b0, count}, 0);
        check("flush_out_valid", out_valid, 0);
        check("flush_err", err, 0);
        out_ready = 1'b1;
        send(OP_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 32'h003100B3, 1, 1);
        drain();

        // fill to DEPTH, then release the consumer with a fifth request pending
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'(i + 8), {12'(i + 8), 20'h00093}, 1, 0);
        check("full_count", {29'b0, count}, 4);
        @(negedge clk);
        check("full_ready", req_ready, 0);
        @(posedge clk); #1;
        fork
            send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd12, 32'h00C00093, 1, 0);
            begin
                step(2);
                out_ready = 1'b1;
                @(negedge clk);
                check("no_passthrough", req_ready, 0);
            end
        join
        drain();

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd1, 32'h00100093, 1, 0);
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2, 32'h00200093, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", {29'b0, count}, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_req_ready", req_ready, 0);
        q.delete();
        model_addr = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1);
        out_ready = 1'b1;
        send(OP_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 32'h003100B3, 1, 1);
        drain();

        // two-bit address tag wraps 0,1,2,3,0
        s_out_ready = 1'b1;
        begin
            int got = 0;
            int n = 0;
            s_req_valid = 1'b1;
            while (got < 5 && n < 50) begin
                @(negedge clk);
                if (s_req_ready) got++;
                @(posedge clk); #1;
                if (got == 5) s_req_valid = 1'b0;
                n++;
            end
            s_req_valid = 1'b0;
        end
        step(5);
        check("wrap_words", s_seen, 5);
        check("queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
